// File: rtl/mux_rr_sel_pkg.sv
// Shared types and defaults for the round-robin channel multiplexer.
// Imported by the interface, the arbiter and the top level.
package mux_pkg;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_RR     = 1'b1;

  localparam int DEF_NUM_CH = 32;
  localparam int DEF_WIDTH  = 2;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_st_e;

endpackage

// File: rtl/mux_rr_sel_if.sv
// Producer-bank / consumer bundle of the channel multiplexer.
// slave is the mux side, master the environment side.
interface mux_rr_sel_if
  import mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH
) ();
  localparam int SEL_W = $clog2(NUM_CH);

  logic                    mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_CH*WIDTH-1:0] in_data;
  logic [NUM_CH-1:0]       in_valid;
  logic [NUM_CH-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready;
  logic                    err_sel;

  modport slave (
    input  mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch, out_valid, err_sel
  );

  modport master (
    output mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch, out_valid, err_sel
  );
endinterface

// File: rtl/mux_rr_sel_rr_arbiter.sv
// Wrap-around priority search: first requester at or above ptr,
// wrapping from NUM_CH-1 back to 0.
module rr_arbiter #(
  parameter int NUM_CH = 32
) (
  input  logic [NUM_CH-1:0]         i_req,
  input  logic [$clog2(NUM_CH)-1:0] i_ptr,
  output logic [NUM_CH-1:0]         o_grant,
  output logic [$clog2(NUM_CH)-1:0] o_idx,
  output logic                      o_any
);
  localparam int SEL_W = $clog2(NUM_CH);

  int               w_k;
  logic [SEL_W-1:0] w_idx;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_k     = 0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_k = int'(i_ptr) + i;
      if (w_k >= NUM_CH) w_k = w_k - NUM_CH;
      w_idx = SEL_W'(w_k);
      if (!o_any && i_req[w_idx]) begin
        o_any          = 1'b1;
        o_grant[w_idx] = 1'b1;
        o_idx          = w_idx;
      end
    end
  end
endmodule

// File: rtl/mux_rr_sel.sv
// Registered N-channel mux with direct select or round-robin scan,
// per-channel valid/ready and a single-entry output register.
module mux_rr_sel
  import mux_pkg::*;
#(
  parameter int NUM_CH = DEF_NUM_CH,
  parameter int WIDTH  = DEF_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_rr_sel_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_CH);

  out_st_e             r_st, w_st_nxt;
  logic [WIDTH-1:0]    r_data;
  logic [SEL_W-1:0]    r_ch;
  logic [SEL_W-1:0]    r_ptr;
  logic                r_err;

  logic                w_load_en;
  logic                w_sel_ok;
  logic [NUM_CH-1:0]   w_dir_oh;
  logic [NUM_CH-1:0]   w_arb_gnt;
  logic [SEL_W-1:0]    w_arb_idx;
  logic                w_arb_any;
  logic [NUM_CH-1:0]   w_ready;
  logic                w_xfer;
  logic [SEL_W-1:0]    w_ch;
  logic [WIDTH-1:0]    w_data;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .i_req   (bus.in_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_arb_gnt),
    .o_idx   (w_arb_idx),
    .o_any   (w_arb_any)
  );

  assign w_load_en = (r_st == ST_EMPTY) | bus.out_ready;
  assign w_sel_ok  = {1'b0, bus.sel} < (SEL_W+1)'(NUM_CH);
  assign w_dir_oh  = NUM_CH'(1) << bus.sel;

  always_comb begin
    w_ready = '0;
    if (rst_n && w_load_en) begin
      if (bus.mode == MODE_RR) begin
        if (w_arb_any) w_ready = w_arb_gnt;
      end else if (w_sel_ok) begin
        w_ready = w_dir_oh;
      end
    end
  end

  assign w_xfer = |(w_ready & bus.in_valid);
  assign w_ch   = (bus.mode == MODE_RR) ? w_arb_idx : bus.sel;

  // One-hot AND-OR select keeps an illegal sel from indexing past in_data
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (w_ready[k]) w_data = w_data | bus.in_data[k*WIDTH +: WIDTH];
  end

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_EMPTY: if (w_xfer) w_st_nxt = ST_FULL;
      ST_FULL:  if (bus.out_ready && !w_xfer) w_st_nxt = ST_EMPTY;
      default:  w_st_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st   <= ST_EMPTY;
      r_data <= '0;
      r_ch   <= '0;
      r_ptr  <= '0;
      r_err  <= 1'b0;
    end else begin
      r_st  <= w_st_nxt;
      r_err <= (bus.mode == MODE_DIRECT) && !w_sel_ok;
      if (w_xfer) begin
        r_data <= w_data;
        r_ch   <= w_ch;
      end
      if (w_xfer && bus.mode == MODE_RR)
        r_ptr <= (w_arb_idx == SEL_W'(NUM_CH-1)) ? '0 : w_arb_idx + 1'b1;
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_data  = r_data;
  assign bus.out_ch    = r_ch;
  assign bus.out_valid = (r_st == ST_FULL);
  assign bus.err_sel   = r_err;
endmodule

// File: tb/tb_mux_rr_sel.sv
// Directed bench for mux_rr_sel: a 32-channel and a 30-channel
// instance, hand-computed expected values.
module tb_mux_rr_sel;
  import mux_pkg::*;

  localparam int N  = 32;
  localparam int N2 = 30;
  localparam int W  = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errs   = 0;
  int   checks = 0;

  mux_rr_sel_if #(.NUM_CH(N),  .WIDTH(W)) b ();
  mux_rr_sel_if #(.NUM_CH(N2), .WIDTH(W)) c ();

  mux_rr_sel #(.NUM_CH(N), .WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  mux_rr_sel #(.NUM_CH(N2), .WIDTH(W)) dut30 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (c.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] dv(input int k);
    return W'((k + 1) % 4);
  endfunction

  function automatic logic [N*W-1:0] pat();
    logic [N*W-1:0] r;
    r = '0;
    for (int k = 0; k < N; k++) r[k*W +: W] = dv(k);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int seq [8] = '{3, 7, 29, 3, 7, 29, 3, 7};
  logic [N*W-1:0] p;

  initial begin
    p = pat();
    rst_n       = 1'b0;
    b.mode      = MODE_DIRECT;
    b.sel       = '0;
    b.in_data   = p;
    b.in_valid  = '1;
    b.out_ready = 1'b1;
    c.mode      = MODE_DIRECT;
    c.sel       = '0;
    c.in_data   = p[N2*W-1:0];
    c.in_valid  = '0;
    c.out_ready = 1'b1;

    #2;
    chk("rst_valid", 64'(b.out_valid), 64'd0);
    chk("rst_data",  64'(b.out_data),  64'd0);
    chk("rst_ch",    64'(b.out_ch),    64'd0);
    chk("rst_err",   64'(b.err_sel),   64'd0);
    chk("rst_ready", 64'(b.in_ready),  64'd0);
    tick();
    tick();
    #2;
    rst_n      = 1'b1;
    b.in_valid = '0;
    tick();

    // illegal select on the 30-channel instance
    c.sel      = 5'd30;
    c.in_valid = '1;
    #1;
    chk("bad30_ready", 64'(c.in_ready), 64'd0);
    tick();
    chk("bad30_err",   64'(c.err_sel),   64'd1);
    chk("bad30_valid", 64'(c.out_valid), 64'd0);
    c.sel = 5'd31;
    #1;
    chk("bad31_ready", 64'(c.in_ready), 64'd0);
    tick();
    chk("bad31_err", 64'(c.err_sel), 64'd1);
    c.sel = 5'd3;
    #1;
    chk("ok3_ready", 64'(c.in_ready), 64'h8);
    tick();
    chk("ok3_err",   64'(c.err_sel),   64'd0);
    chk("ok3_valid", 64'(c.out_valid), 64'd1);
    chk("ok3_ch",    64'(c.out_ch),    64'd3);
    c.in_valid = '0;
    tick();
    chk("c_drain_valid", 64'(c.out_valid), 64'd0);
    chk("c_drain_err",   64'(c.err_sel),   64'd0);

    // direct select of channel 5
    b.mode     = MODE_DIRECT;
    b.sel      = 5'd5;
    b.in_valid = 32'h20;
    #1;
    chk("dir5_ready", 64'(b.in_ready), 64'h20);
    tick();
    chk("dir5_valid", 64'(b.out_valid), 64'd1);
    chk("dir5_data",  64'(b.out_data),  64'd2);
    chk("dir5_ch",    64'(b.out_ch),    64'd5);
    b.in_valid = '0;
    tick();
    chk("dir5_drain", 64'(b.out_valid), 64'd0);

    // round-robin over 3, 7, 29 with wrap
    b.mode     = MODE_RR;
    b.in_valid = 32'h2000_0088;
    #1;
    chk("rr_first_ready", 64'(b.in_ready), 64'h8);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("rr_ch%0d", i), 64'(b.out_ch), 64'(seq[i]));
      chk($sformatf("rr_v%0d", i), 64'(b.out_valid), 64'd1);
    end
    chk("rr_data29_wrap", 64'(b.out_data), 64'(dv(7)));

    // backpressure hold with out_ch = 7
    b.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("hold_ready%0d", i), 64'(b.in_ready), 64'd0);
      tick();
      chk($sformatf("hold_ch%0d", i), 64'(b.out_ch), 64'd7);
      chk($sformatf("hold_v%0d", i), 64'(b.out_valid), 64'd1);
    end

    // release in direct mode: back-to-back loads, ptr untouched
    b.mode      = MODE_DIRECT;
    b.sel       = 5'd2;
    b.in_valid  = '1;
    b.out_ready = 1'b1;
    #1;
    chk("rel_ready", 64'(b.in_ready), 64'h4);
    tick();
    chk("rel_ch",    64'(b.out_ch),    64'd2);
    chk("rel_data",  64'(b.out_data),  64'd3);
    chk("rel_valid", 64'(b.out_valid), 64'd1);
    b.sel = 5'd12;
    tick();
    chk("dir12_ch",   64'(b.out_ch),   64'd12);
    chk("dir12_data", 64'(b.out_data), 64'd1);

    // back to round-robin: search resumes from ptr = 8
    b.mode     = MODE_RR;
    b.in_valid = 32'h2000_0888;
    #1;
    chk("rr_resume_ready", 64'(b.in_ready), 64'h800);
    tick();
    chk("rr_resume_ch", 64'(b.out_ch), 64'd11);
    b.out_ready = 1'b0;

    // asynchronous reset while FULL
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(b.out_valid), 64'd0);
    chk("arst_ch",    64'(b.out_ch),    64'd0);
    chk("arst_data",  64'(b.out_data),  64'd0);
    chk("arst_err",   64'(b.err_sel),   64'd0);
    chk("arst_ready", 64'(b.in_ready),  64'd0);
    #2;
    rst_n       = 1'b1;
    b.in_valid  = '1;
    b.out_ready = 1'b1;
    #1;
    chk("post_rst_ready", 64'(b.in_ready), 64'h1);
    tick();
    chk("post_rst_ch",    64'(b.out_ch),    64'd0);
    chk("post_rst_data",  64'(b.out_data),  64'd1);
    chk("post_rst_valid", 64'(b.out_valid), 64'd1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
